// File: rtl/alu_op_sequencer.sv
// Issue stage for the 4-bit ALU: replays a buffered program of up to DEPTH operations,
// captures each ALU result and hands it downstream on a valid/ready interface.
module alu_op_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [10:0]   wr_data,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [2:0]    alu_op,
    input  logic [7:0]    alu_y,
    input  logic          alu_flagc,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [7:0]    res_y,
    output logic          res_c,
    output logic          res_z,
    output logic [AW-1:0] res_idx,
    output logic [AW:0]   zero_cnt,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    function automatic logic is_zero(input logic [7:0] y);
        is_zero = (y == 8'h00);
    endfunction

    state_t        state_r;
    logic [10:0]   mem_r [DEPTH];
    logic [AW-1:0] ptr_r;
    logic [AW:0]   len_r;
    logic [3:0]    alu_a_r;
    logic [3:0]    alu_b_r;
    logic [2:0]    alu_op_r;
    logic          res_valid_r;
    logic [7:0]    res_y_r;
    logic          res_c_r;
    logic          res_z_r;
    logic [AW-1:0] res_idx_r;
    logic [AW:0]   zero_cnt_r;
    logic          busy_r;
    logic          done_r;

    logic          advance_s;
    logic          last_s;
    logic          zero_s;
    logic [AW-1:0] next_ptr_s;
    logic [10:0]   next_entry_s;
    logic [10:0]   first_entry_s;
    logic [AW:0]   len_clamp_s;
    logic          wr_ok_s;

    // Next-operation decode, length clamp and same-cycle write bypass for entry 0
    always_comb begin
        advance_s    = !res_valid_r || res_ready;
        last_s       = ({1'b0, ptr_r} == (len_r - LEN_ONE));
        zero_s       = is_zero(alu_y);
        next_ptr_s   = ptr_r + PTR_ONE;
        next_entry_s = mem_r[next_ptr_s];
        wr_ok_s      = wr_en && (state_r == IDLE);
        if (len > DEPTH_W) begin
            len_clamp_s = DEPTH_W;
        end else begin
            len_clamp_s = len;
        end
        // A write issued together with start must already be seen by the first fetch
        if (wr_en && (wr_addr == {AW{1'b0}})) begin
            first_entry_s = wr_data;
        end else begin
            first_entry_s = mem_r[0];
        end
    end

    // Program buffer write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (!rst && wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= {AW{1'b0}};
            len_r       <= {(AW+1){1'b0}};
            alu_a_r     <= 4'd0;
            alu_b_r     <= 4'd0;
            alu_op_r    <= 3'd0;
            res_valid_r <= 1'b0;
            res_y_r     <= 8'h00;
            res_c_r     <= 1'b0;
            res_z_r     <= 1'b0;
            res_idx_r   <= {AW{1'b0}};
            zero_cnt_r  <= {(AW+1){1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        zero_cnt_r <= {(AW+1){1'b0}};
                        if (len_clamp_s == {(AW+1){1'b0}}) begin
                            done_r <= 1'b1;
                        end else begin
                            len_r    <= len_clamp_s;
                            ptr_r    <= {AW{1'b0}};
                            alu_op_r <= first_entry_s[10:8];
                            alu_a_r  <= first_entry_s[7:4];
                            alu_b_r  <= first_entry_s[3:0];
                            state_r  <= RUN;
                            busy_r   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (advance_s) begin
                        res_y_r     <= alu_y;
                        res_c_r     <= (alu_op_r == 3'b000) & alu_flagc;
                        res_z_r     <= zero_s;
                        res_idx_r   <= ptr_r;
                        res_valid_r <= 1'b1;
                        zero_cnt_r  <= zero_cnt_r + {{AW{1'b0}}, zero_s};
                        // Operands hold on the last entry so the ALU output stays quiet in DRAIN
                        if (last_s) begin
                            state_r <= DRAIN;
                        end else begin
                            ptr_r    <= next_ptr_s;
                            alu_op_r <= next_entry_s[10:8];
                            alu_a_r  <= next_entry_s[7:4];
                            alu_b_r  <= next_entry_s[3:0];
                        end
                    end
                end
                DRAIN: begin
                    if (res_valid_r && res_ready) begin
                        res_valid_r <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign res_valid = res_valid_r;
    assign res_y     = res_y_r;
    assign res_c     = res_c_r;
    assign res_z     = res_z_r;
    assign res_idx   = res_idx_r;
    assign zero_cnt  = zero_cnt_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream issue stage for the 4-bit ALU; a program of up to 8 ALU operations is loaded into a local buffer.
- On start, the block drives a/b/opcode from registered outputs, one operation per cycle.
- It captures each combinational ALU result and hands it downstream on a valid/ready interface.
- It counts zero results, and reports busy and done.

Parameters:
- DEPTH, 8, program buffer entries; must be a power of 2, max 8.
- AW, 3, buffer address width, log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  program write strobe; honoured only in IDLE.
- wr_addr  in  AW  program entry index.
- wr_data  in  11  entry, packed as {opcode[10:8], a[7:4], b[3:0]}.
- start  in  1  begin execution; honoured only in IDLE.
- len  in  AW+1  number of entries to run, 0..DEPTH, sampled with start.
- alu_a  out  4  operand a to ALU, registered.
- alu_b  out  4  operand b to ALU, registered.
- alu_op  out  3  opcode to ALU, registered.
- alu_y  in  8  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_flagc  in  1  ALU carry flag; meaningful only for opcode 000.
- res_valid  out  1  result register holds an unconsumed result.
- res_ready  in  1  consumer accepts the result this cycle.
- res_y  out  8  captured result.
- res_c  out  1  carry: alu_flagc if the captured opcode is 000, else 0.
- res_z  out  1  1 when captured alu_y == 8'h00; computed locally, not taken from the ALU.
- res_idx  out  AW  buffer index of the captured result.
- zero_cnt  out  AW+1  number of results with res_z=1 captured in the current run.
- busy  out  1  state != IDLE.
- done  out  1  single-cycle pulse when the run has fully drained.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE.
  - alu_a/alu_b/alu_op=0; res_valid=0; res_y=0; res_c=0; res_z=0; res_idx=0; zero_cnt=0; done=0.
  - Buffer contents are not reset.
  - Reset mid-run aborts immediately; no done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - wr_en writes wr_data to mem[wr_addr].
  - start with len==0: done=1 next cycle, state stays IDLE, zero_cnt cleared.
  - start with len>0:
    - latch len;
    - ptr=0; zero_cnt=0;
    - load alu_a/b/op from mem[0];
    - go RUN.
  - start and wr_en in the same cycle: the write happens first; the write is visible to the run.
- RUN:
  - Capture condition: advance = !res_valid || res_ready.
  - On advance:
    - res_y=alu_y;
    - res_c=(alu_op==3'b000)&alu_flagc;
    - res_z=(alu_y==0);
    - res_idx=ptr;
    - res_valid=1;
    - zero_cnt += res_z.
  - If ptr==len-1: go DRAIN, operands hold. Otherwise: ptr++, load operands from mem[ptr+1].
  - Without advance, all registers hold, and the ALU inputs stay stable.
- Throughput and latency:
  - One result per cycle with res_ready held high.
  - First res_valid is high 2 cycles after the start edge: E0 loads operands, E1 captures.
- DRAIN:
  - When res_valid && res_ready: res_valid=0, done=1 for exactly one cycle, go IDLE.
- Ignored inputs:
  - wr_en and start are ignored in RUN/DRAIN.
  - len is sampled only with start.
- Handshake rules:
  - Once res_valid is high, res_* stay stable until accepted.
  - A result is accepted and a new one captured in the same cycle when res_ready=1.
- Width rules:
  - zero_cnt cannot overflow (max DEPTH).
  - ptr wraps only at len; len>DEPTH is clamped to DEPTH.

Test Plan:
- Bench connects the team's ALU model to alu_a/alu_b/alu_op/alu_y/alu_flagc.
- Basic run:
  - Stimulus: load {000,2,3}, {011,2,3}, {010,F,F}, {011,5,A}; len=4; res_ready=1.
  - Response: res_y=05,02,E1,00 on consecutive cycles; res_idx=0..3; first valid 2 cycles after start; zero_cnt=4'd1; done one cycle after the last accept; busy low after done.
- Backpressure:
  - Stimulus: same program; res_ready low for 3 cycles while entry 1 is valid.
  - Response: res_y holds 02 and alu_op holds 010; no result lost or duplicated.
- Carry mask:
  - Stimulus: {000,F,F} then {010,8,4} with a forced alu_flagc=1.
  - Response: res_y=1E then 20; res_c=alu_flagc for entry 0; res_c=0 for entry 1.
- Edge starts:
  - Stimulus: start with len=0.
  - Response: done pulses one cycle after start, busy never rises.
  - Stimulus: start while busy.
  - Response: ignored.
  - Stimulus: wr_en during RUN.
  - Response: the buffer entry is unchanged.
- Reset mid-run:
  - Stimulus: rst asserted on the 2nd result.
  - Response: all outputs 0 next cycle, no done pulse; a subsequent start with len=1 runs normally and gives zero_cnt per result.
